// File: rtl/fifo_sync_fwft_ctrl_pkg.sv
// fifo_pkg: shared constants and helpers for the single-clock FIFO controller.
//   CONFIG_*        width-config codes for the SRAM macro (1..7)
//   FIFO_MODE_*     values of the cfg_fwft_i mode input
//   cfg_to_depth_log2  log2 of the FIFO depth in words for a width code
package fifo_pkg;

  localparam logic [2:0] CONFIG_1BIT  = 3'd1;
  localparam logic [2:0] CONFIG_2BIT  = 3'd2;
  localparam logic [2:0] CONFIG_4BIT  = 3'd3;
  localparam logic [2:0] CONFIG_9BIT  = 3'd4;
  localparam logic [2:0] CONFIG_18BIT = 3'd5;
  localparam logic [2:0] CONFIG_36BIT = 3'd6;
  localparam logic [2:0] CONFIG_80BIT = 3'd7;

  localparam logic FIFO_MODE_STD  = 1'b0;
  localparam logic FIFO_MODE_FWFT = 1'b1;

  // Each step up in word width halves the number of words the macro holds.
  // Code 0 is not a legal width and is treated as the widest configuration.
  function automatic int unsigned cfg_to_depth_log2(input logic [2:0] cfg,
                                                    input int unsigned addr_width);
    logic [2:0] code;
    code = (cfg == 3'd0) ? CONFIG_80BIT : cfg;
    return addr_width + 1 - 32'(code);
  endfunction

endpackage

// File: rtl/fifo_sync_fwft_ctrl_if.sv
// fifo_sync_fwft_ctrl_if: configuration, request, SRAM-control and status
// signals of the FIFO controller.
//   master: fabric side (drives config and requests, observes status/RAM control)
//   slave : the controller itself
interface fifo_sync_fwft_ctrl_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [2:0]            cfg_width_i;
  logic                  cfg_fwft_i;
  logic [ADDR_WIDTH-1:0] cfg_almost_full_offset_i;
  logic [ADDR_WIDTH-1:0] cfg_almost_empty_offset_i;
  logic                  wr_en_i;
  logic                  rd_en_i;
  logic                  err_clr_i;
  logic                  ram_we_o;
  logic                  ram_re_o;
  logic [ADDR_WIDTH:0]   ram_wr_addr_o;
  logic [ADDR_WIDTH:0]   ram_rd_addr_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  write_error_o;
  logic                  read_error_o;
  logic [ADDR_WIDTH:0]   level_o;
  logic [ADDR_WIDTH-1:0] write_address_o;
  logic [ADDR_WIDTH-1:0] read_address_o;

  modport master (
    output cfg_width_i, cfg_fwft_i, cfg_almost_full_offset_i, cfg_almost_empty_offset_i,
    output wr_en_i, rd_en_i, err_clr_i,
    input  ram_we_o, ram_re_o, ram_wr_addr_o, ram_rd_addr_o,
    input  full_o, empty_o, almost_full_o, almost_empty_o,
    input  write_error_o, read_error_o, level_o, write_address_o, read_address_o
  );

  modport slave (
    input  cfg_width_i, cfg_fwft_i, cfg_almost_full_offset_i, cfg_almost_empty_offset_i,
    input  wr_en_i, rd_en_i, err_clr_i,
    output ram_we_o, ram_re_o, ram_wr_addr_o, ram_rd_addr_o,
    output full_o, empty_o, almost_full_o, almost_empty_o,
    output write_error_o, read_error_o, level_o, write_address_o, read_address_o
  );
endinterface

// File: rtl/fifo_sync_fwft_ctrl_ptr_cnt.sv
// fifo_ptr_cnt: wrapping pointer counter with increment enable and
// synchronous clear.
//   clk  : clock, rising edge
//   clr  : synchronous clear to zero (wins over inc)
//   inc  : advance the pointer by one
//   mask : 2*DEPTH-1; the pointer wraps to 0 after reaching this value
//   ptr  : current pointer, top used bit is the wrap bit
module fifo_ptr_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_reg;
  logic [WIDTH-1:0] ptr_next;

  // Masking after the add makes the wrap point follow the configured depth.
  always_comb begin
    ptr_next = ptr_reg;
    if (inc) ptr_next = (ptr_reg + WIDTH'(1)) & mask;
  end

  always_ff @(posedge clk) begin
    if (clr) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_sync_fwft_ctrl.sv
// fifo_sync_fwft_ctrl: single-clock FIFO controller for one SRAM macro
// (port A read, port B write), with standard and first-word-fall-through
// modes, fill level, almost flags and sticky error flags.
//   clk_i     : clock, rising edge
//   reset_n_i : synchronous active-low reset
//   bus       : config, requests, SRAM control and status (slave modport)
// ADDR_WIDTH must be at least 7 so the widest configuration keeps >= 2 words.
module fifo_sync_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  fifo_sync_fwft_ctrl_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 1;

  int unsigned           depth_log2;
  logic [PW-1:0]         depth;
  logic [PW-1:0]         ptr_mask;
  logic [ADDR_WIDTH-1:0] addr_mask;
  logic [PW-1:0]         ptr [2];
  logic [1:0]            inc;
  logic [PW-1:0]         mem_cnt;
  logic [PW-1:0]         level;
  logic [PW-1:0]         af_off;
  logic [PW-1:0]         ae_off;
  logic                  fwft;
  logic                  full;
  logic                  mem_nz;
  logic                  wr_accept;
  logic                  rd_inc;
  logic                  prefetch;
  logic                  wr_err;
  logic                  rd_err;
  logic                  dout_valid_reg, dout_valid_next;
  logic                  write_error_reg, read_error_reg;

  assign depth_log2 = cfg_to_depth_log2(bus.cfg_width_i, ADDR_WIDTH);
  assign depth      = PW'(1) << depth_log2;
  // At the 1-bit config 2*DEPTH overflows PW bits to 0, giving an all-ones mask.
  assign ptr_mask   = (depth << 1) - PW'(1);
  assign addr_mask  = ptr_mask[PW-1:1];
  assign fwft       = (bus.cfg_fwft_i == FIFO_MODE_FWFT);

  // Words held in the SRAM; in FWFT mode the word already fetched to the
  // SRAM output is no longer counted here.
  assign mem_cnt = (ptr[0] - ptr[1]) & ptr_mask;
  assign full    = (mem_cnt == depth);
  assign mem_nz  = (mem_cnt != '0);

  assign wr_accept = bus.wr_en_i & ~full;
  assign wr_err    = bus.wr_en_i & full;
  assign prefetch  = mem_nz & (~dout_valid_reg | bus.rd_en_i);
  assign rd_inc    = fwft ? prefetch : (bus.rd_en_i & mem_nz);
  assign rd_err    = fwft ? (bus.rd_en_i & ~dout_valid_reg) : (bus.rd_en_i & ~mem_nz);

  assign inc[0] = wr_accept;
  assign inc[1] = rd_inc;

  // Index 0 is the write pointer, index 1 the read pointer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      fifo_ptr_cnt #(.WIDTH(PW)) u_cnt (
        .clk  (clk_i),
        .clr  (~reset_n_i),
        .inc  (inc[gi]),
        .mask (ptr_mask),
        .ptr  (ptr[gi])
      );
    end
  endgenerate

  always_comb begin
    dout_valid_next = 1'b0;
    if (fwft) begin
      if (prefetch)                             dout_valid_next = 1'b1;
      else if (bus.rd_en_i && dout_valid_reg)   dout_valid_next = 1'b0;
      else                                      dout_valid_next = dout_valid_reg;
    end
  end

  // A new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      dout_valid_reg  <= 1'b0;
      write_error_reg <= 1'b0;
      read_error_reg  <= 1'b0;
    end else begin
      dout_valid_reg  <= dout_valid_next;
      write_error_reg <= wr_err | (write_error_reg & ~bus.err_clr_i);
      read_error_reg  <= rd_err | (read_error_reg & ~bus.err_clr_i);
    end
  end

  assign level  = mem_cnt + PW'(fwft & dout_valid_reg);
  assign af_off = PW'(bus.cfg_almost_full_offset_i);
  assign ae_off = PW'(bus.cfg_almost_empty_offset_i);

  assign bus.ram_we_o        = reset_n_i & wr_accept;
  assign bus.ram_re_o        = reset_n_i & rd_inc;
  assign bus.write_address_o = ptr[0][ADDR_WIDTH-1:0] & addr_mask;
  assign bus.read_address_o  = ptr[1][ADDR_WIDTH-1:0] & addr_mask;
  assign bus.ram_wr_addr_o   = {bus.write_address_o, 1'b0};
  assign bus.ram_rd_addr_o   = {bus.read_address_o, 1'b0};

  // Status depends only on registered pointers and dout_valid.
  assign bus.full_o         = full;
  assign bus.empty_o        = fwft ? ~dout_valid_reg : ~mem_nz;
  assign bus.level_o        = level;
  assign bus.almost_full_o  = (af_off >= depth) | (level >= depth - af_off);
  assign bus.almost_empty_o = (ae_off >= depth) | (level <= ae_off);
  assign bus.write_error_o  = write_error_reg;
  assign bus.read_error_o   = read_error_reg;

endmodule

// File: tb/tb_fifo_sync_fwft_ctrl.sv
// Scoreboard bench for fifo_sync_fwft_ctrl. The driver computes the expected
// outputs of each cycle from a queue-based model of the FIFO contents and
// pushes them; a monitor on the falling edge pops and compares.
module tb_fifo_sync_fwft_ctrl;
  import fifo_pkg::*;

  localparam int AW = 15;

  typedef struct {
    bit we, re, full, empty, af, ae, werr, rerr;
    int level, wr_addr, rd_addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_fwft_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  fifo_sync_fwft_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  exp_t exp_q[$];
  int   wq[$];
  int   rq[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: q holds the sequence numbers of words stored in the SRAM, held
  // marks a word presented on the SRAM output in FWFT mode.
  int q[$];
  bit held;
  int wr_total;
  bit werr_m, rerr_m;
  int depth;
  bit fwft_m;
  int af_off, ae_off;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit clr, input bit rstn);
    exp_t e;
    int lvl;
    bit wacc, racc, new_werr, new_rerr;
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.err_clr_i = clr;
    reset_n = rstn;
    lvl = q.size() + ((fwft_m && held) ? 1 : 0);
    e.full  = (q.size() == depth);
    e.empty = fwft_m ? !held : (q.size() == 0);
    e.level = lvl;
    e.af    = (af_off >= depth) || (lvl >= depth - af_off);
    e.ae    = (ae_off >= depth) || (lvl <= ae_off);
    e.werr  = werr_m;
    e.rerr  = rerr_m;
    e.wr_addr = wr_total % depth;
    e.rd_addr = (q.size() != 0) ? (q[0] % depth) : (wr_total % depth);
    wacc = wr && (q.size() < depth);
    if (fwft_m) racc = (q.size() != 0) && (!held || rd);
    else        racc = rd && (q.size() != 0);
    e.we = rstn && wacc;
    e.re = rstn && racc;
    exp_q.push_back(e);
    if (e.we) wq.push_back(e.wr_addr * 2);
    if (e.re) rq.push_back(e.rd_addr * 2);
    if (!rstn) begin
      q.delete();
      held = 0;
      werr_m = 0;
      rerr_m = 0;
      wr_total = 0;
    end else begin
      new_werr = wr && (q.size() == depth);
      new_rerr = fwft_m ? (rd && !held) : (rd && (q.size() == 0));
      if (racc) begin
        void'(q.pop_front());
        if (fwft_m) held = 1;
      end else if (fwft_m && rd && held) begin
        held = 0;
      end
      if (wacc) begin
        q.push_back(wr_total);
        wr_total++;
      end
      werr_m = new_werr || (werr_m && !clr);
      rerr_m = new_rerr || (rerr_m && !clr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Config only changes while reset is held; the first (unchecked) reset
  // cycle brings the DUT out of its unknown power-up state.
  task automatic configure(input logic [2:0] cfg, input bit fwft, input int af, input int ae);
    bus.wr_en_i = 0;
    bus.rd_en_i = 0;
    bus.err_clr_i = 0;
    reset_n = 0;
    bus.cfg_width_i = cfg;
    bus.cfg_fwft_i = fwft;
    bus.cfg_almost_full_offset_i = AW'(af);
    bus.cfg_almost_empty_offset_i = AW'(ae);
    @(posedge clk);
    #1;
    depth = 1 << (AW - ((cfg == 3'd0) ? 6 : (int'(cfg) - 1)));
    fwft_m = fwft;
    af_off = af;
    ae_off = ae;
    q.delete();
    held = 0;
    wr_total = 0;
    werr_m = 0;
    rerr_m = 0;
    step(0, 0, 0, 0);
    $display("config cfg=%0d fwft=%0d depth=%0d af=%0d ae=%0d", cfg, fwft, depth, af, ae);
  endtask

  task automatic rand_run(input int n, input int wp, input int rp);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 19) == 0, 1);
    $display("random batch n=%0d wr%%=%0d rd%%=%0d level=%0d", n, wp, rp,
             q.size() + ((fwft_m && held) ? 1 : 0));
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("ram_we", bus.ram_we_o, e.we);
        chk("ram_re", bus.ram_re_o, e.re);
        chk("full", bus.full_o, e.full);
        chk("empty", bus.empty_o, e.empty);
        chk("almost_full", bus.almost_full_o, e.af);
        chk("almost_empty", bus.almost_empty_o, e.ae);
        chk("write_error", bus.write_error_o, e.werr);
        chk("read_error", bus.read_error_o, e.rerr);
        chk("level", bus.level_o, e.level);
        chk("write_address", bus.write_address_o, e.wr_addr);
        chk("read_address", bus.read_address_o, e.rd_addr);
      end
      if (bus.ram_we_o === 1'b1) begin
        vectors++;
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL ram_wr_addr cycle %0d: got strobe at %0d expected none", cyc, bus.ram_wr_addr_o);
        end else begin
          chk("ram_wr_addr", bus.ram_wr_addr_o, wq.pop_front());
        end
      end
      if (bus.ram_re_o === 1'b1) begin
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL ram_rd_addr cycle %0d: got strobe at %0d expected none", cyc, bus.ram_rd_addr_o);
        end else begin
          chk("ram_rd_addr", bus.ram_rd_addr_o, rq.pop_front());
        end
      end
    end
  end

  // Driver
  initial begin
    bus.cfg_width_i = CONFIG_80BIT;
    bus.cfg_fwft_i = FIFO_MODE_STD;
    bus.cfg_almost_full_offset_i = '0;
    bus.cfg_almost_empty_offset_i = '0;
    bus.wr_en_i = 0;
    bus.rd_en_i = 0;
    bus.err_clr_i = 0;
    @(posedge clk);
    #1;

    // Standard mode, DEPTH 512: read while empty, then 3 writes / 3 reads.
    configure(CONFIG_80BIT, FIFO_MODE_STD, 2, 5);
    step(0, 1, 0, 1);
    $display("txn read-while-empty");
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 1); $display("txn write %0d", i); end
    for (int i = 0; i < 3; i++) begin step(0, 1, 0, 1); $display("txn read %0d", i); end
    step(0, 0, 0, 1);

    // Fill to full, overflow, clear, then drain to 300 and reset.
    for (int i = 0; i < 512; i++) step(1, 0, 0, 1);
    $display("txn filled 512 words");
    step(1, 0, 0, 1);
    $display("txn write while full");
    step(1, 1, 0, 1);
    $display("txn write while full with read");
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 211; i++) step(0, 1, 0, 1);
    $display("txn drained to level %0d", q.size());
    step(1, 1, 0, 0);
    $display("txn reset mid-operation");
    step(0, 0, 0, 1);
    rand_run(1500, 60, 50);

    // DEPTH 1024: long biased runs to hit full/empty and wrap the pointers.
    configure(CONFIG_36BIT, FIFO_MODE_STD, $urandom_range(0, 40), $urandom_range(0, 40));
    rand_run(1800, 90, 30);
    rand_run(1800, 30, 90);
    rand_run(1800, 90, 30);
    rand_run(1800, 10, 95);

    // FWFT: first-word latency and pop.
    configure(CONFIG_80BIT, FIFO_MODE_FWFT, 2, 5);
    step(1, 0, 0, 1);
    $display("txn fwft single write");
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    $display("txn fwft pop");
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    $display("txn fwft pop while empty");
    step(0, 0, 1, 1);

    // FWFT: level 5, simultaneous read/write, then one extra write.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    $display("txn fwft simultaneous rd/wr at level 5");
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    $display("txn fwft write to level 6");
    step(0, 0, 0, 1);
    rand_run(1200, 90, 30);
    rand_run(1200, 30, 90);

    // Code 0 behaves as the widest config; offsets beyond DEPTH saturate.
    configure(3'd0, FIFO_MODE_FWFT, 600, 600);
    rand_run(400, 50, 50);
    configure(3'd0, FIFO_MODE_STD, $urandom_range(0, 30), $urandom_range(0, 30));
    rand_run(1500, 70, 40);
    rand_run(800, 20, 90);

    bus.wr_en_i = 0;
    bus.rd_en_i = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0 || wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d/%0d pending expected 0/0/0", exp_q.size(), wq.size(), rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
